// File: rtl/vx_alu_dotp_acc.sv
// Packed int4/int8/int16 dot product with optional rs3 accumulate and signed-32 saturation.
// Per-lane arithmetic lives in vx_alu_dotp_lane; the top owns the stallable valid/tag pipe.

module vx_alu_dotp_lane #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  op_mode,
  input  logic [1:0]  op_signed,
  input  logic        op_acc,
  input  logic        op_sat,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rs3,
  output logic [31:0] res
);
  localparam logic signed [35:0] MAX_S32 = 36'sh0_7FFF_FFFF;
  localparam logic signed [35:0] MIN_S32 = 36'shF_8000_0000;

  logic [7:0][16:0] a_e, b_e;
  logic [7:0][33:0] prod_c;
  logic [31:0]      addend_c;
  logic [31:0]      res_d, res_q;

  function automatic logic signed [35:0] reduce(input logic [7:0][33:0] p, input logic [31:0] add);
    logic signed [35:0] s;
    s = 36'($signed(add));
    for (int i = 0; i < 8; i++) s = s + 36'($signed(p[i]));
    return s;
  endfunction

  function automatic logic [31:0] clamp(input logic signed [35:0] f, input logic sat);
    if (sat && f > MAX_S32) return 32'h7FFF_FFFF;
    if (sat && f < MIN_S32) return 32'h8000_0000;
    return f[31:0];
  endfunction

  // Every element is widened to 17-bit signed so one multiplier shape serves all modes;
  // mode 11 leaves all elements and the addend at zero, which yields a zero result.
  always_comb begin
    a_e = '0;
    b_e = '0;
    case (op_mode)
      2'b00: for (int i = 0; i < 4; i++) begin
        a_e[i] = {{9{op_signed[0] & rs1[8*i+7]}}, rs1[8*i +: 8]};
        b_e[i] = {{9{op_signed[1] & rs2[8*i+7]}}, rs2[8*i +: 8]};
      end
      2'b01: for (int i = 0; i < 8; i++) begin
        a_e[i] = {{13{op_signed[0] & rs1[4*i+3]}}, rs1[4*i +: 4]};
        b_e[i] = {{13{op_signed[1] & rs2[4*i+3]}}, rs2[4*i +: 4]};
      end
      2'b10: for (int i = 0; i < 2; i++) begin
        a_e[i] = {op_signed[0] & rs1[16*i+15], rs1[16*i +: 16]};
        b_e[i] = {op_signed[1] & rs2[16*i+15], rs2[16*i +: 16]};
      end
      default: ;
    endcase
    for (int i = 0; i < 8; i++) prod_c[i] = 34'($signed(a_e[i])) * 34'($signed(b_e[i]));
    addend_c = (op_acc && op_mode != 2'b11) ? rs3 : '0;
  end

  if (LATENCY == 1) begin : g_lat1
    always_comb res_d = clamp(reduce(prod_c, addend_c), op_sat);
  end else begin : g_latn
    logic [7:0][33:0]   prod_q;
    logic [31:0]        addend_q;
    logic [LATENCY-2:0] sat_q, sat_d;
    logic signed [35:0] full_c;

    always_comb begin
      sat_d    = '0;
      sat_d[0] = op_sat;
      for (int k = 1; k < LATENCY - 1; k++) sat_d[k] = sat_q[k-1];
      full_c = reduce(prod_q, addend_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prod_q   <= '0;
        addend_q <= '0;
        sat_q    <= '0;
      end else if (en) begin
        prod_q   <= prod_c;
        addend_q <= addend_c;
        sat_q    <= sat_d;
      end
    end

    if (LATENCY == 2) begin : g_l2
      always_comb res_d = clamp(full_c, sat_q[0]);
    end else begin : g_l3
      // Extra depth is spent as plain delay on the reduced sum before the clamp.
      logic [LATENCY-3:0][35:0] full_q, full_d;
      always_comb begin
        full_d    = '0;
        full_d[0] = full_c;
        for (int k = 1; k < LATENCY - 2; k++) full_d[k] = full_q[k-1];
        res_d = clamp($signed(full_q[LATENCY-3]), sat_q[LATENCY-2]);
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset)   full_q <= '0;
        else if (en) full_q <= full_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   res_q <= '0;
    else if (en) res_q <= res_d;
  end

  assign res = res_q;
endmodule

module vx_alu_dotp_acc #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [1:0]                op_mode,
  input  logic [1:0]                op_signed,
  input  logic                      op_acc,
  input  logic                      op_sat,
  input  logic [NUM_LANES*XLEN-1:0] rs1_data,
  input  logic [NUM_LANES*XLEN-1:0] rs2_data,
  input  logic [NUM_LANES*XLEN-1:0] rs3_data,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [TAG_WIDTH-1:0]      tag_out
);
  logic                               en;
  logic [LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][TAG_WIDTH-1:0]  tag_pipe_q, tag_pipe_d;
  logic [NUM_LANES-1:0][31:0]         lane_res;

  assign valid_out = vld_pipe_q[LATENCY-1];
  assign tag_out   = tag_pipe_q[LATENCY-1];
  assign en        = ~valid_out | ready_out;
  assign ready_in  = en;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    tag_pipe_d = tag_pipe_q;
    if (en) begin
      vld_pipe_d[0] = valid_in;
      tag_pipe_d[0] = tag_in;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        tag_pipe_d[k] = tag_pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_alu_dotp_lane #(.LATENCY(LATENCY)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .op_mode   (op_mode),
      .op_signed (op_signed),
      .op_acc    (op_acc),
      .op_sat    (op_sat),
      .rs1       (rs1_data[l*XLEN +: 32]),
      .rs2       (rs2_data[l*XLEN +: 32]),
      .rs3       (rs3_data[l*XLEN +: 32]),
      .res       (lane_res[l])
    );
    assign data_out[l*XLEN +: XLEN] = XLEN'($signed(lane_res[l]));
  end
endmodule

// File: tb/tb_vx_alu_dotp_acc.sv
// Directed bench for vx_alu_dotp_acc: vector table, back-pressure, throughput and reset cases.

module tb_vx_alu_dotp_acc;
  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 2;
  localparam int TW  = 8;
  localparam int NV  = 17;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in, ready_in, valid_out, ready_out;
  logic [1:0]       op_mode, op_signed;
  logic             op_acc, op_sat;
  logic [NL*XL-1:0] rs1_data, rs2_data, rs3_data, data_out;
  logic [TW-1:0]    tag_in, tag_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sgn;
    logic        acc;
    logic        sat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [NV];

  vx_alu_dotp_acc #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .op_mode(op_mode), .op_signed(op_signed), .op_acc(op_acc), .op_sat(op_sat),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [TW-1:0] t);
    valid_in  = 1'b1;
    op_mode   = v.mode;
    op_signed = v.sgn;
    op_acc    = v.acc;
    op_sat    = v.sat;
    tag_in    = t;
    for (int l = 0; l < NL; l++) begin
      rs1_data[l*XL +: XL] = v.a;
      rs2_data[l*XL +: XL] = v.b;
      rs3_data[l*XL +: XL] = v.c;
    end
  endtask

  initial begin
    int   sent, got;
    logic stall_prev, accepted;
    logic [TW-1:0]    held_tag;
    logic [NL*XL-1:0] held_data;
    vec_t vs;

    //      mode   sgn    acc   sat   rs1           rs2           rs3           expected
    vt[0]  = '{2'b00, 2'b11, 1'b0, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0,        32'h0000FC04};
    vt[1]  = '{2'b00, 2'b11, 1'b0, 1'b0, 32'h80808080, 32'h7F7F7F7F, 32'h0,        32'hFFFF0200};
    vt[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h22222222, 32'h0,        32'hFFFFFFF0};
    vt[3]  = '{2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h22222222, 32'h0,        32'h000000F0};
    vt[4]  = '{2'b10, 2'b11, 1'b0, 1'b1, 32'h80008000, 32'h80008000, 32'h0,        32'h7FFFFFFF};
    vt[5]  = '{2'b10, 2'b11, 1'b0, 1'b0, 32'h80008000, 32'h80008000, 32'h0,        32'h80000000};
    vt[6]  = '{2'b00, 2'b11, 1'b1, 1'b1, 32'h01010101, 32'h01010101, 32'h7FFFFFFE, 32'h7FFFFFFF};
    vt[7]  = '{2'b00, 2'b11, 1'b1, 1'b0, 32'h01010101, 32'h01010101, 32'h7FFFFFFE, 32'h80000002};
    vt[8]  = '{2'b11, 2'b11, 1'b1, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h12345678, 32'h00000000};
    vt[9]  = '{2'b10, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFC0002};
    vt[10] = '{2'b10, 2'b00, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h7FFFFFFF};
    vt[11] = '{2'b10, 2'b01, 1'b0, 1'b1, 32'h80008000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vt[12] = '{2'b10, 2'b01, 1'b0, 1'b0, 32'h80008000, 32'hFFFFFFFF, 32'h0,        32'h00010000};
    vt[13] = '{2'b00, 2'b11, 1'b1, 1'b1, 32'h000000FF, 32'h00000001, 32'h80000000, 32'h80000000};
    vt[14] = '{2'b00, 2'b11, 1'b1, 1'b0, 32'h000000FF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF};
    vt[15] = '{2'b00, 2'b10, 1'b0, 1'b0, 32'h000000FF, 32'h000000FF, 32'h0,        32'hFFFFFF01};
    vt[16] = '{2'b01, 2'b11, 1'b0, 1'b0, 32'h00000087, 32'h00000033, 32'h0,        32'hFFFFFFFD};

    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    op_mode = '0; op_signed = '0; op_acc = 1'b0; op_sat = 1'b0;
    rs1_data = '0; rs2_data = '0; rs3_data = '0; tag_in = '0;
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data",  data_out[31:0], 32'd0);
    chk("rst_tag",   32'(tag_out), 32'd0);
    chk("rst_ready", 32'(ready_in), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Table: one op at a time, latency and per-lane result checked.
    for (int v = 0; v < NV; v++) begin
      drive(vt[v], TW'(v));
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (v == 0) chk("lat_early", 32'(valid_out), 32'd0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", v), 32'(valid_out), 32'd1);
      chk($sformatf("vec%0d_tag", v), 32'(tag_out), 32'(v));
      for (int l = 0; l < NL; l++)
        chk($sformatf("vec%0d_lane%0d", v, l), data_out[l*XL +: XL], vt[v].exp);
    end
    @(posedge clk); #1;

    // Back-pressure: ready_out 1,0,0 repeating; lane l of op n computes (n+l)*(-5).
    sent = 0; got = 0; stall_prev = 1'b0; held_tag = '0; held_data = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      ready_out = (cyc % 3 == 0);
      valid_in  = (sent < 8);
      op_mode = 2'b00; op_signed = 2'b11; op_acc = 1'b0; op_sat = 1'b0;
      tag_in = TW'(sent);
      for (int l = 0; l < NL; l++) begin
        rs1_data[l*XL +: XL] = 32'(sent + l);
        rs2_data[l*XL +: XL] = 32'h000000FB;
        rs3_data[l*XL +: XL] = 32'h0;
      end
      @(negedge clk);
      if (stall_prev) begin
        chk("bp_hold_valid", 32'(valid_out), 32'd1);
        chk("bp_hold_tag", 32'(tag_out), 32'(held_tag));
        chk("bp_hold_data", data_out[NL*XL-1 -: 32], held_data[NL*XL-1 -: 32]);
      end
      if (valid_out && !ready_out) chk("bp_ready_in", 32'(ready_in), 32'd0);
      if (valid_out && ready_out) begin
        chk("bp_tag", 32'(tag_out), 32'(got));
        for (int l = 0; l < NL; l++)
          chk($sformatf("bp_data%0d_lane%0d", got, l), data_out[l*XL +: XL], 32'(-5 * (got + l)));
        got++;
      end
      stall_prev = valid_out && !ready_out;
      held_tag   = tag_out;
      held_data  = data_out;
      accepted   = valid_in && ready_in;
      @(posedge clk); #1;
      if (accepted) sent++;
    end
    chk("bp_count", 32'(got), 32'd8);
    valid_in = 1'b0; ready_out = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;

    // Throughput with ready_out held: 4 back-to-back ops, results on consecutive cycles.
    for (int c = 0; c < LAT + 6; c++) begin
      vs = vt[0];
      if (c < 4) drive(vs, TW'(8'h40 + c));
      else valid_in = 1'b0;
      @(negedge clk);
      chk($sformatf("tp_valid_c%0d", c), 32'(valid_out), 32'((c >= LAT) && (c < LAT + 4)));
      if (c >= LAT && c < LAT + 4) chk($sformatf("tp_tag_c%0d", c), 32'(tag_out), 32'(8'h40 + c - LAT));
      @(posedge clk); #1;
    end

    // Reset with two operations in flight.
    drive(vt[4], 8'hA1);
    @(posedge clk); #1;
    drive(vt[6], 8'hB2);
    @(posedge clk); #1;
    valid_in = 1'b0; ready_out = 1'b0;
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_data", data_out[31:0], 32'd0);
    chk("mid_rst_tag", 32'(tag_out), 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0; ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), 32'(valid_out), 32'd0);
    end
    @(posedge clk); #1;
    drive(vt[13], 8'h5C);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    chk("post_rst_tag", 32'(tag_out), 32'h5C);
    chk("post_rst_data", data_out[31:0], 32'h80000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
